// File: rtl/mem_frame_pkg.sv
// Shared definitions for the frame-buffer write path: bus widths and sequencer states.
package mem_frame_pkg;

    localparam int unsigned ADDR_BITS = 27;
    localparam int unsigned LEN_BITS  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StBurst,
        StDone
    } wr_state_e;

endpackage

// File: rtl/frame_idx_next.sv
// Next frame-buffer index: rotate modulo FRAME_NUM, hopping over the buffer the reader holds.
module frame_idx_next #(
    parameter int unsigned FRAME_NUM = 3
) (
    input  logic [1:0] i_cur_idx,
    input  logic [1:0] i_busy_idx,
    output logic [1:0] o_nxt_idx
);

    logic [1:0] w_inc1;
    logic [1:0] w_inc2;

    // one-step and two-step rotation; take the second when the first is busy
    always_comb begin
        w_inc1    = (i_cur_idx >= 2'(FRAME_NUM - 1)) ? 2'd0 : i_cur_idx + 2'd1;
        w_inc2    = (w_inc1 >= 2'(FRAME_NUM - 1)) ? 2'd0 : w_inc1 + 2'd1;
        o_nxt_idx = (w_inc1 == i_busy_idx) ? w_inc2 : w_inc1;
    end

endmodule

// File: rtl/mem_frame_wr_ctrl.sv
// Frame-buffer write sequencer: drains the capture FIFO into rotating frame buffers in bursts.
module mem_frame_wr_ctrl
    import mem_frame_pkg::*;
#(
    parameter int unsigned          MEM_DATA_BITS = 32,
    parameter int unsigned          BURST_LEN     = 64,
    parameter int unsigned          FRAME_WORDS   = 393216,
    parameter logic [ADDR_BITS-1:0] FRAME_STRIDE  = 27'h80000,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 27'h0,
    parameter int unsigned          FRAME_NUM     = 3,
    parameter int unsigned          FIFO_CNT_BITS = 11
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     calib_done,
    input  logic                     frame_start,
    input  logic [FIFO_CNT_BITS-1:0] fifo_rdusedw,
    input  logic [MEM_DATA_BITS-1:0] fifo_q,
    output logic                     fifo_rd_en,
    output logic                     wr_burst_req,
    output logic [LEN_BITS-1:0]      wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    input  logic [1:0]               rd_busy_idx,
    output logic [1:0]               wr_frame_idx,
    output logic [1:0]               done_frame_idx,
    output logic                     frame_done,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned REM_BITS = $clog2(FRAME_WORDS + 1);

    wr_state_e             r_state;
    wr_state_e             w_state_nxt;
    logic [REM_BITS-1:0]   r_remaining;
    logic [LEN_BITS-1:0]   r_len;
    logic [LEN_BITS-1:0]   w_len;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  w_frame_base;
    logic [1:0]            r_wr_idx;
    logic [1:0]            r_done_idx;
    logic [1:0]            w_idx_nxt;
    logic [7:0]            r_drop;
    logic                  w_start_ok;
    logic                  w_launch;

    frame_idx_next #(
        .FRAME_NUM (FRAME_NUM)
    ) u_idx_next (
        .i_cur_idx  (r_wr_idx),
        .i_busy_idx (rd_busy_idx),
        .o_nxt_idx  (w_idx_nxt)
    );

    // burst sizing, launch condition and frame base address
    always_comb begin
        if (32'(r_remaining) >= BURST_LEN) begin
            w_len = LEN_BITS'(BURST_LEN);
        end else begin
            w_len = LEN_BITS'(r_remaining);
        end
        w_start_ok   = frame_start && calib_done && (r_state == StIdle);
        // no launch while calibration is low; an in-flight burst still completes
        w_launch     = calib_done && (32'(fifo_rdusedw) >= 32'(w_len));
        w_frame_base = BASE_ADDR + ADDR_BITS'(r_wr_idx) * FRAME_STRIDE;
    end

    // state register
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:     if (w_start_ok) w_state_nxt = StWaitData;
            StWaitData: if (w_launch) w_state_nxt = StBurst;
            StBurst: begin
                if (wr_burst_finish) begin
                    w_state_nxt = (32'(r_remaining) == 32'(r_len)) ? StDone : StWaitData;
                end
            end
            StDone:     w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
    end

    // burst address/length, remaining words, buffer indices and drop counter
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_wr_idx    <= 2'd0;
            r_done_idx  <= 2'(FRAME_NUM - 1);
            r_drop      <= 8'd0;
        end else begin
            if (frame_start && !w_start_ok && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_remaining <= REM_BITS'(FRAME_WORDS);
                        r_addr      <= w_frame_base;
                    end
                end
                StWaitData: begin
                    if (w_launch) r_len <= w_len;
                end
                StBurst: begin
                    if (wr_burst_finish) begin
                        r_addr      <= r_addr + ADDR_BITS'(r_len);
                        r_remaining <= r_remaining - REM_BITS'(r_len);
                    end
                end
                StDone: begin
                    r_done_idx <= r_wr_idx;
                    r_wr_idx   <= w_idx_nxt;
                end
                default: ;
            endcase
        end
    end

    // state-decoded outputs; FIFO pop and data pass straight through during a burst
    always_comb begin
        wr_burst_req = (r_state == StBurst);
        frame_done   = (r_state == StDone);
        fifo_rd_en   = wr_burst_req && wr_burst_data_req;
    end

    assign wr_burst_data  = fifo_q;
    assign wr_burst_len   = r_len;
    assign wr_burst_addr  = r_addr;
    assign wr_frame_idx   = r_wr_idx;
    assign done_frame_idx = r_done_idx;
    assign drop_cnt       = r_drop;

endmodule
